// File: rtl/coin_accumulator.sv
// coin_accumulator: multi-denomination payment accumulator with vend/change handshake.
// Optional cancel/refund path enabled by defining COIN_ACC_REFUND_EN.
module coin_accumulator #(
    parameter int                    NCH    = 3,
    parameter int                    VAL_W  = 19,
    parameter int                    CNT_W  = 9,
    parameter logic [NCH*VAL_W-1:0]  DENOMS = {19'd5000, 19'd2000, 19'd1000}
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic                   Start,
    input  logic [VAL_W-1:0]       Price,
    input  logic [NCH-1:0]         Pulse,
`ifdef COIN_ACC_REFUND_EN
    input  logic                   Cancel,
`endif
    input  logic                   Vend_ack,
    output logic                   Busy,
    output logic                   Vend_valid,
    output logic                   Refund,
    output logic [VAL_W-1:0]       Change,
    output logic [VAL_W-1:0]       Total,
    output logic [NCH*CNT_W-1:0]   Counts,
    output logic                   Overflow
);

    // Extra headroom so the raw sum of every channel plus the total cannot wrap.
    localparam int SUM_W = VAL_W + $clog2(NCH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_VEND
    } state_t;

    state_t                 r_state;
    logic [VAL_W-1:0]       r_price;
    logic [VAL_W-1:0]       r_total;
    logic [NCH*CNT_W-1:0]   r_counts;
    logic                   r_ovf;
    logic [VAL_W-1:0]       r_change;
    logic                   r_refund;

    state_t                 w_state_nxt;
    logic [VAL_W-1:0]       w_price_nxt;
    logic [VAL_W-1:0]       w_total_nxt;
    logic [NCH*CNT_W-1:0]   w_counts_nxt;
    logic                   w_ovf_nxt;
    logic [VAL_W-1:0]       w_change_nxt;
    logic                   w_refund_nxt;

    logic [SUM_W-1:0]       w_sum;
    logic                   w_tot_sat;
    logic [VAL_W-1:0]       w_total_new;
    logic [NCH*CNT_W-1:0]   w_counts_new;
    logic                   w_cnt_sat;
    logic                   w_cancel;

`ifdef COIN_ACC_REFUND_EN
    assign w_cancel = Cancel;
`else
    assign w_cancel = 1'b0;
`endif

    // Credit every pulsed channel this cycle and saturate the result.
    always_comb begin
        w_sum = SUM_W'(r_total);
        for (int i = 0; i < NCH; i++) begin
            if (Pulse[i]) begin
                w_sum = w_sum + SUM_W'(DENOMS[i*VAL_W +: VAL_W]);
            end
        end
        w_tot_sat   = (w_sum > SUM_W'({VAL_W{1'b1}}));
        w_total_new = w_tot_sat ? {VAL_W{1'b1}} : w_sum[VAL_W-1:0];
    end

    // Per-channel counters that hold at all-ones instead of wrapping.
    always_comb begin
        w_counts_new = r_counts;
        w_cnt_sat    = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (Pulse[i]) begin
                if (&r_counts[i*CNT_W +: CNT_W]) begin
                    w_cnt_sat = 1'b1;
                end else begin
                    w_counts_new[i*CNT_W +: CNT_W] =
                        r_counts[i*CNT_W +: CNT_W] + CNT_W'(1);
                end
            end
        end
    end

    // Transaction FSM: next state and next register values.
    always_comb begin
        w_state_nxt  = r_state;
        w_price_nxt  = r_price;
        w_total_nxt  = r_total;
        w_counts_nxt = r_counts;
        w_ovf_nxt    = r_ovf;
        w_change_nxt = r_change;
        w_refund_nxt = r_refund;
        unique case (r_state)
            S_IDLE: begin
                if (Start) begin
                    w_state_nxt  = S_COLLECT;
                    w_price_nxt  = Price;
                    w_total_nxt  = '0;
                    w_counts_nxt = '0;
                    w_ovf_nxt    = 1'b0;
                    w_change_nxt = '0;
                end
            end
            S_COLLECT: begin
                w_total_nxt  = w_total_new;
                w_counts_nxt = w_counts_new;
                w_ovf_nxt    = r_ovf | w_tot_sat | w_cnt_sat;
                if (w_cancel) begin
                    w_state_nxt  = S_VEND;
                    w_change_nxt = w_total_new;
                    w_refund_nxt = 1'b1;
                end else if (w_total_new >= r_price) begin
                    w_state_nxt  = S_VEND;
                    w_change_nxt = w_total_new - r_price;
                    w_refund_nxt = 1'b0;
                end
            end
            S_VEND: begin
                if (Vend_ack) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state  <= S_IDLE;
            r_price  <= '0;
            r_total  <= '0;
            r_counts <= '0;
            r_ovf    <= 1'b0;
            r_change <= '0;
            r_refund <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_price  <= w_price_nxt;
            r_total  <= w_total_nxt;
            r_counts <= w_counts_nxt;
            r_ovf    <= w_ovf_nxt;
            r_change <= w_change_nxt;
            r_refund <= w_refund_nxt;
        end
    end

    assign Busy       = (r_state != S_IDLE);
    assign Vend_valid = (r_state == S_VEND);
    assign Refund     = r_refund;
    assign Change     = r_change;
    assign Total      = r_total;
    assign Counts     = r_counts;
    assign Overflow   = r_ovf;

endmodule

// File: tb/tb_coin_accumulator.sv
// tb_coin_accumulator: vector table with scoreboard plus hand-written corner sequences.
// Refund vectors are included when COIN_ACC_REFUND_EN is defined.
module tb_coin_accumulator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start;
    logic [18:0] price;
    logic [2:0]  pulse;
    logic        cancel;
    logic        ack;
    logic        busy, vv, refund, ovf;
    logic [18:0] change, total;
    logic [26:0] counts;

    logic        s_start;
    logic [12:0] s_price;
    logic [2:0]  s_pulse;
    logic        s_cancel;
    logic        s_ack;
    logic        s_busy, s_vv, s_refund, s_ovf;
    logic [12:0] s_change, s_total;
    logic [5:0]  s_counts;

    coin_accumulator dut (
        .Clock(clk), .Reset(rst), .Start(start), .Price(price),
        .Pulse(pulse),
`ifdef COIN_ACC_REFUND_EN
        .Cancel(cancel),
`endif
        .Vend_ack(ack), .Busy(busy), .Vend_valid(vv), .Refund(refund),
        .Change(change), .Total(total), .Counts(counts), .Overflow(ovf)
    );

    coin_accumulator #(
        .NCH(3), .VAL_W(13), .CNT_W(2),
        .DENOMS({13'd5000, 13'd2000, 13'd1000})
    ) dut_s (
        .Clock(clk), .Reset(rst), .Start(s_start), .Price(s_price),
        .Pulse(s_pulse),
`ifdef COIN_ACC_REFUND_EN
        .Cancel(s_cancel),
`endif
        .Vend_ack(s_ack), .Busy(s_busy), .Vend_valid(s_vv),
        .Refund(s_refund), .Change(s_change), .Total(s_total),
        .Counts(s_counts), .Overflow(s_ovf)
    );

    typedef struct {
        logic        start;
        logic [18:0] price;
        logic [2:0]  pulse;
        logic        cancel;
        logic        ack;
        logic        e_busy;
        logic        e_vv;
        logic        e_ref;
        logic [18:0] e_total;
        logic [18:0] e_chg;
        logic [26:0] e_cnt;
        logic        e_ovf;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];
    int   n_chk = 0;
    int   n_err = 0;

    function automatic logic [26:0] c3(int a2, int a1, int a0);
        return {9'(a2), 9'(a1), 9'(a0)};
    endfunction

    function automatic vec_t mk(int st, int pr, int pu, int ca, int ak,
                                int bu, int v, int rf, int tot, int chg,
                                logic [26:0] cnt, int ov);
        vec_t r;
        r.start   = 1'(st);
        r.price   = 19'(pr);
        r.pulse   = 3'(pu);
        r.cancel  = 1'(ca);
        r.ack     = 1'(ak);
        r.e_busy  = 1'(bu);
        r.e_vv    = 1'(v);
        r.e_ref   = 1'(rf);
        r.e_total = 19'(tot);
        r.e_chg   = 19'(chg);
        r.e_cnt   = cnt;
        r.e_ovf   = 1'(ov);
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t e;
        rst = 1'b1; start = 1'b0; price = '0; pulse = '0;
        cancel = 1'b0; ack = 1'b0;
        s_start = 1'b0; s_price = '0; s_pulse = '0;
        s_cancel = 1'b0; s_ack = 1'b0;

        // sale 3500: 1000+2000 then 1000
        tbl.push_back(mk(1, 3500, 0, 0, 0, 1, 0, 0, 0, 0, c3(0, 0, 0), 0));
        tbl.push_back(mk(0, 0, 3, 0, 0, 1, 0, 0, 3000, 0, c3(0, 1, 1), 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 1, 1, 0, 4000, 500, c3(0, 1, 2), 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 4000, 500, c3(0, 1, 2), 0));
        // all three channels in one cycle
        tbl.push_back(mk(1, 7000, 0, 0, 0, 1, 0, 0, 0, 0, c3(0, 0, 0), 0));
        tbl.push_back(mk(0, 0, 7, 0, 0, 1, 1, 0, 8000, 1000, c3(1, 1, 1), 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 8000, 1000, c3(1, 1, 1), 0));
        // ack without valid, Start in COLLECT, held VEND
        tbl.push_back(mk(1, 2000, 0, 0, 0, 1, 0, 0, 0, 0, c3(0, 0, 0), 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, c3(0, 0, 0), 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, c3(0, 0, 0), 0));
        tbl.push_back(mk(0, 0, 2, 0, 0, 1, 1, 0, 2000, 0, c3(0, 1, 0), 0));
        for (int k = 0; k < 5; k++)
            tbl.push_back(mk(1, 0, 7, 1, 0, 1, 1, 0, 2000, 0, c3(0, 1, 0), 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 2000, 0, c3(0, 1, 0), 0));
        // price 0 with ack tied high
        tbl.push_back(mk(1, 0, 0, 0, 1, 1, 0, 0, 0, 0, c3(0, 0, 0), 0));
        tbl.push_back(mk(0, 0, 4, 0, 1, 1, 1, 0, 5000, 5000, c3(1, 0, 0), 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 5000, 5000, c3(1, 0, 0), 0));
`ifdef COIN_ACC_REFUND_EN
        tbl.push_back(mk(1, 9000, 0, 0, 0, 1, 0, 0, 0, 0, c3(0, 0, 0), 0));
        tbl.push_back(mk(0, 0, 2, 0, 0, 1, 0, 0, 2000, 0, c3(0, 1, 0), 0));
        tbl.push_back(mk(0, 0, 1, 1, 0, 1, 1, 1, 3000, 3000, c3(0, 1, 1), 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 1, 3000, 3000, c3(0, 1, 1), 0));
        tbl.push_back(mk(1, 1000, 0, 0, 0, 1, 0, 1, 0, 0, c3(0, 0, 0), 0));
        tbl.push_back(mk(0, 0, 1, 1, 0, 1, 1, 1, 1000, 1000, c3(0, 0, 1), 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 1, 1000, 1000, c3(0, 0, 1), 0));
`endif

        // reset state
        step();
        step();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_vv", 32'(vv), 0);
        chk("rst_total", 32'(total), 0);
        chk("rst_counts", 32'(counts), 0);
        chk("rst_change", 32'(change), 0);
        chk("rst_ovf", 32'(ovf), 0);
        chk("rst_refund", 32'(refund), 0);
        rst = 1'b0;
        step();

        foreach (tbl[i]) begin
            start  = tbl[i].start;
            price  = tbl[i].price;
            pulse  = tbl[i].pulse;
            cancel = tbl[i].cancel;
            ack    = tbl[i].ack;
            sb.push_back(tbl[i]);
            step();
            e = sb.pop_front();
            chk($sformatf("v%0d_busy", i), 32'(busy), 32'(e.e_busy));
            chk($sformatf("v%0d_valid", i), 32'(vv), 32'(e.e_vv));
            chk($sformatf("v%0d_refund", i), 32'(refund), 32'(e.e_ref));
            chk($sformatf("v%0d_total", i), 32'(total), 32'(e.e_total));
            chk($sformatf("v%0d_change", i), 32'(change), 32'(e.e_chg));
            chk($sformatf("v%0d_counts", i), 32'(counts), 32'(e.e_cnt));
            chk($sformatf("v%0d_ovf", i), 32'(ovf), 32'(e.e_ovf));
        end
        start = 1'b0; price = '0; pulse = '0; cancel = 1'b0; ack = 1'b0;
        step();

        // small instance: total saturation at 8191
        s_start = 1'b1; s_price = 13'd8191;
        step();
        s_start = 1'b0; s_pulse = 3'b100;
        step();
        chk("sat_total1", 32'(s_total), 5000);
        chk("sat_vv1", 32'(s_vv), 0);
        step();
        s_pulse = '0;
        chk("sat_total2", 32'(s_total), 8191);
        chk("sat_ovf", 32'(s_ovf), 1);
        chk("sat_vv2", 32'(s_vv), 1);
        chk("sat_change", 32'(s_change), 0);
        chk("sat_counts", 32'(s_counts), 32);
        s_ack = 1'b1;
        step();
        s_ack = 1'b0;
        chk("sat_idle", 32'(s_busy), 0);

        // small instance: count saturation at 3
        s_start = 1'b1;
        step();
        s_start = 1'b0;
        chk("cnt_ovf_clr", 32'(s_ovf), 0);
        s_pulse = 3'b001;
        step();
        step();
        step();
        chk("cnt_3", 32'(s_counts), 3);
        chk("cnt_ovf0", 32'(s_ovf), 0);
        step();
        s_pulse = '0;
        chk("cnt_hold", 32'(s_counts), 3);
        chk("cnt_total", 32'(s_total), 4000);
        chk("cnt_ovf1", 32'(s_ovf), 1);
        chk("cnt_vv", 32'(s_vv), 0);

        // asynchronous reset mid-COLLECT
        start = 1'b1; price = 19'd9000;
        step();
        start = 1'b0; pulse = 3'b010;
        step();
        pulse = 3'b001;
        step();
        pulse = '0;
        chk("mid_total", 32'(total), 3000);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_busy", 32'(busy), 0);
        chk("ar_total", 32'(total), 0);
        chk("ar_counts", 32'(counts), 0);
        chk("ar_vv", 32'(vv), 0);
        chk("ar_small_busy", 32'(s_busy), 0);
        step();
        rst = 1'b0;
        start = 1'b1; price = 19'd1000;
        step();
        start = 1'b0;
        chk("rs_busy", 32'(busy), 1);
        chk("rs_total", 32'(total), 0);
        pulse = 3'b001;
        step();
        pulse = '0;
        chk("rs_total2", 32'(total), 1000);
        chk("rs_vv", 32'(vv), 1);
        chk("rs_change", 32'(change), 0);
        ack = 1'b1;
        step();
        ack = 1'b0;
        chk("rs_idle", 32'(busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
